// File: rtl/immpack_pkg.sv
// Shared immediate-format codes and field positions for the packer and the extender.
// Combinational helpers only; no latency or flow control lives here.
// Positions are the LSB of each scattered field in the 32-bit instruction word.
package immpack_pkg;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_X = 2'b11;

    localparam int I_IMM_LSB  = 20;
    localparam int S_HI_LSB   = 25;
    localparam int S_LO_LSB   = 7;
    localparam int B_SIGN_BIT = 31;
    localparam int B_HI_LSB   = 25;
    localparam int B_LO_LSB   = 8;
    localparam int B_B11_BIT  = 7;

    // True when v is the sign-extension of its low 'bits' bits.
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned bits);
        logic signed [31:0] t;
        t = $signed(v) >>> (bits - 1);
        return (t == '0) || (t == '1);
    endfunction

endpackage

// File: rtl/immpack_fmt.sv
// Scatters a signed immediate into I/S/B fields of a base word and flags range/format errors.
// Purely combinational, zero latency; no flow control.
// On error the truncated fields are still merged so the word is never dropped.
module immpack_fmt
    import immpack_pkg::*;
(
    input  logic [31:0] base_instr_i,
    input  logic [1:0]  immsrc_i,
    input  logic [31:0] imm_i,
    output logic [31:0] word_o,
    output logic        err_o
);

    always_comb begin
        word_o = base_instr_i;
        err_o  = 1'b0;
        case (immsrc_i)
            IMM_I: begin
                word_o[I_IMM_LSB +: 12] = imm_i[11:0];
                err_o                   = !fits_signed(imm_i, 12);
            end
            IMM_S: begin
                word_o[S_HI_LSB +: 7] = imm_i[11:5];
                word_o[S_LO_LSB +: 5] = imm_i[4:0];
                err_o                 = !fits_signed(imm_i, 12);
            end
            IMM_B: begin
                word_o[B_SIGN_BIT]    = imm_i[12];
                word_o[B_HI_LSB +: 6] = imm_i[10:5];
                word_o[B_LO_LSB +: 4] = imm_i[4:1];
                word_o[B_B11_BIT]     = imm_i[11];
                err_o                 = imm_i[0] || !fits_signed(imm_i, 13);
            end
            default: err_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/immpack.sv
// Immediate packer: two-stage valid/ready pipeline around immpack_fmt, optional error counter (IMMPACK_ERRCNT_EN).
// Latency 2 cycles accept-to-out_valid, 1 word/cycle throughput.
// Backpressure: stages advance only into free/draining slots; in_ready is combinational from out_ready.
module immpack
    import immpack_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      base_instr,
    input  logic [1:0]       immsrc,
    input  logic [31:0]      imm_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic             err_out,
    output logic [CNT_W-1:0] err_count
);

    logic [31:0] fmt_word;
    logic        fmt_err;

    logic        s1_vld_q, s1_vld_d;
    logic [31:0] s1_word_q, s1_word_d;
    logic        s1_err_q, s1_err_d;
    logic        s2_vld_q, s2_vld_d;
    logic [31:0] s2_word_q, s2_word_d;
    logic        s2_err_q, s2_err_d;
    logic        s1_adv, s2_adv;

    immpack_fmt u_fmt (
        .base_instr_i (base_instr),
        .immsrc_i     (immsrc),
        .imm_i        (imm_in),
        .word_o       (fmt_word),
        .err_o        (fmt_err)
    );

    assign s2_adv   = !s2_vld_q || out_ready;
    assign s1_adv   = !s1_vld_q || s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_vld_d  = s1_vld_q;
        s1_word_d = s1_word_q;
        s1_err_d  = s1_err_q;
        s2_vld_d  = s2_vld_q;
        s2_word_d = s2_word_q;
        s2_err_d  = s2_err_q;
        if (s1_adv) begin
            s1_vld_d = in_valid;
            if (in_valid) begin
                s1_word_d = fmt_word;
                s1_err_d  = fmt_err;
            end
        end
        // Payload only moves with a valid word so the held output stays stable.
        if (s2_adv) begin
            s2_vld_d = s1_vld_q;
            if (s1_vld_q) begin
                s2_word_d = s1_word_q;
                s2_err_d  = s1_err_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q  <= 1'b0;
            s1_word_q <= '0;
            s1_err_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
            s2_word_q <= '0;
            s2_err_q  <= 1'b0;
        end else begin
            s1_vld_q  <= s1_vld_d;
            s1_word_q <= s1_word_d;
            s1_err_q  <= s1_err_d;
            s2_vld_q  <= s2_vld_d;
            s2_word_q <= s2_word_d;
            s2_err_q  <= s2_err_d;
        end
    end

    assign out_valid = s2_vld_q;
    assign instr_out = s2_word_q;
    assign err_out   = s2_err_q;

`ifdef IMMPACK_ERRCNT_EN
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (out_valid && out_ready && err_out && (err_cnt_q != '1))
            err_cnt_d = err_cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_immpack.sv
// Directed bench for immpack: field packing, range errors, saturation, backpressure, mid-stream reset.
module tb_immpack;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base_instr;
    logic [1:0]  immsrc;
    logic [31:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        err_out;
    logic [1:0]  err_count;

    int checks   = 0;
    int failures = 0;
    int exp_cnt  = 0;

    immpack #(.CNT_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .base_instr (base_instr),
        .immsrc     (immsrc),
        .imm_in     (imm_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_out  (instr_out),
        .err_out    (err_out),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] b, input logic [1:0] s, input logic [31:0] i);
        in_valid   = 1'b1;
        base_instr = b;
        immsrc     = s;
        imm_in     = i;
    endtask

    function automatic int next_cnt(input int c, input logic e);
`ifdef IMMPACK_ERRCNT_EN
        return (e && c < 3) ? c + 1 : c;
`else
        return 0;
`endif
    endfunction

    // One isolated transaction with out_ready high: accept, 2-cycle latency, emit.
    task automatic xact(input string tag, input logic [31:0] b, input logic [1:0] s,
                        input logic [31:0] i, input logic [31:0] exp_w, input logic exp_e);
        drive(b, s, i);
        check({tag, ".rdy"}, in_ready, 1);
        check({tag, ".idle"}, out_valid, 0);
        step();
        in_valid = 1'b0;
        check({tag, ".lat1"}, out_valid, 0);
        step();
        check({tag, ".vld"}, out_valid, 1);
        check({tag, ".word"}, instr_out, exp_w);
        check({tag, ".err"}, err_out, exp_e);
        step();
        exp_cnt = next_cnt(exp_cnt, exp_e);
        check({tag, ".cnt"}, err_count, exp_cnt);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        base_instr = '0; immsrc = '0; imm_in = '0;
        #1;
        check("rst.out_valid", out_valid, 0);
        check("rst.instr", instr_out, 0);
        check("rst.err", err_out, 0);
        check("rst.cnt", err_count, 0);
        step(); step();
        rst_n = 1'b1;
        #1;
        check("rst.in_ready", in_ready, 1);
        step();

        xact("i_neg",   32'h00000013, 2'b00, 32'hFFFFF800, 32'h80000013, 1'b0);
        xact("i_pos",   32'h00000013, 2'b00, 32'h000007FF, 32'h7FF00013, 1'b0);
        xact("s_7f",    32'h00002023, 2'b01, 32'h0000007F, 32'h06002FA3, 1'b0);
        xact("b_m2",    32'h00000063, 2'b10, 32'hFFFFFFFE, 32'hFE000FE3, 1'b0);
        xact("b_max",   32'h00000063, 2'b10, 32'h00000FFE, 32'h7E000FE3, 1'b0);
        xact("i_ovf",   32'h00000013, 2'b00, 32'h00000800, 32'h80000013, 1'b1);
        xact("b_odd",   32'h00000063, 2'b10, 32'h00000003, 32'h00000163, 1'b1);
        xact("x_fmt",   32'h12345678, 2'b11, 32'h00000000, 32'h12345678, 1'b1);
        xact("s_ovf",   32'h00002023, 2'b01, 32'h00000800, 32'h80002023, 1'b1);
        xact("b_ovf",   32'h00000063, 2'b10, 32'h00001000, 32'h80000063, 1'b1);

        // Backpressure: two accepts fill the pipe, third waits for release.
        out_ready = 1'b0;
        #1;
        drive(32'h00000013, 2'b00, 32'h00000001);
        check("bp.a_rdy", in_ready, 1);
        step();
        drive(32'h00000013, 2'b00, 32'h00000002);
        check("bp.b_rdy", in_ready, 1);
        check("bp.b_vld", out_valid, 0);
        step();
        drive(32'h00000013, 2'b00, 32'h00000003);
        check("bp.c_rdy0", in_ready, 0);
        check("bp.a_vld", out_valid, 1);
        check("bp.a_word", instr_out, 32'h00100013);
        step();
        check("bp.hold_rdy", in_ready, 0);
        check("bp.hold_word", instr_out, 32'h00100013);
        check("bp.hold_vld", out_valid, 1);
        step();
        check("bp.hold2_word", instr_out, 32'h00100013);
        out_ready = 1'b1;
        #1;
        check("bp.rel_rdy", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp.b_out_vld", out_valid, 1);
        check("bp.b_word", instr_out, 32'h00200013);
        step();
        check("bp.c_out_vld", out_valid, 1);
        check("bp.c_word", instr_out, 32'h00300013);
        step();
        check("bp.drained", out_valid, 0);

        // Reset with both stages holding error words.
        out_ready = 1'b0;
        drive(32'h0, 2'b11, 32'h0);
        step();
        drive(32'h1, 2'b11, 32'h0);
        step();
        in_valid = 1'b0;
        check("mid.full_vld", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.out_valid", out_valid, 0);
        check("mid.instr", instr_out, 0);
        check("mid.err", err_out, 0);
        check("mid.cnt", err_count, 0);
        exp_cnt = 0;
        step();
        rst_n = 1'b1;
        out_ready = 1'b1;
        #1;
        check("mid.in_ready", in_ready, 1);
        step();
        check("mid.no_ghost", out_valid, 0);
        xact("post_rst", 32'h00000013, 2'b00, 32'h00000005, 32'h00500013, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
